// File: rtl/res_station_if.sv
// rtl/res_station_if.sv - issue, CDB and functional-unit signal bundle for res_station
interface res_station_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 3,
    parameter int OP_W  = 4
);
    logic             flush_i;
    logic             load_i;
    logic [OP_W-1:0]  op_i;
    logic [TAG_W-1:0] dest_tag_i;
    logic             src1_rdy_i;
    logic [TAG_W-1:0] src1_tag_i;
    logic [XLEN-1:0]  src1_val_i;
    logic             src2_rdy_i;
    logic [TAG_W-1:0] src2_tag_i;
    logic [XLEN-1:0]  src2_val_i;
    logic             cdb_valid_i;
    logic [TAG_W-1:0] cdb_tag_i;
    logic [XLEN-1:0]  cdb_data_i;
    logic             free_o;
    logic             fu_valid_o;
    logic             fu_ready_i;
    logic [OP_W-1:0]  fu_op_o;
    logic [XLEN-1:0]  fu_a_o;
    logic [XLEN-1:0]  fu_b_o;
    logic [TAG_W-1:0] fu_tag_o;

    modport master (
        output flush_i, load_i, op_i, dest_tag_i,
        output src1_rdy_i, src1_tag_i, src1_val_i,
        output src2_rdy_i, src2_tag_i, src2_val_i,
        output cdb_valid_i, cdb_tag_i, cdb_data_i, fu_ready_i,
        input  free_o, fu_valid_o, fu_op_o, fu_a_o, fu_b_o, fu_tag_o
    );

    modport slave (
        input  flush_i, load_i, op_i, dest_tag_i,
        input  src1_rdy_i, src1_tag_i, src1_val_i,
        input  src2_rdy_i, src2_tag_i, src2_val_i,
        input  cdb_valid_i, cdb_tag_i, cdb_data_i, fu_ready_i,
        output free_o, fu_valid_o, fu_op_o, fu_a_o, fu_b_o, fu_tag_o
    );
endinterface

// File: rtl/res_station.sv
// rtl/res_station.sv - reservation station, CDB wakeup, oldest-ready dispatch; RS_WAKEUP_BYPASS_EN enables zero-latency wakeup
module res_station #(
    parameter int ENTRIES = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 4
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    res_station_if.slave bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_READY} ent_state_t;

    ent_state_t       state_q  [ENTRIES];
    logic [OP_W-1:0]  op_q     [ENTRIES];
    logic [TAG_W-1:0] dest_q   [ENTRIES];
    logic             s1_rdy_q [ENTRIES];
    logic [TAG_W-1:0] s1_tag_q [ENTRIES];
    logic [XLEN-1:0]  s1_val_q [ENTRIES];
    logic             s2_rdy_q [ENTRIES];
    logic [TAG_W-1:0] s2_tag_q [ENTRIES];
    logic [XLEN-1:0]  s2_val_q [ENTRIES];
    // older_q[i][j] set means entry i was allocated before entry j
    logic [ENTRIES-1:0] older_q [ENTRIES];
    // lock keeps the presented entry stable while the FU stalls
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;

    logic [ENTRIES-1:0] hit1, hit2, wake, eligible;
    logic               free, any_eligible, blocked, fu_valid, hs, do_load;
    logic [IDX_W-1:0]   alloc_idx, pick_idx, sel_idx;
    logic               ld_hit1, ld_hit2;

    // CDB tag match and operand wakeup per entry
    always_comb begin
        hit1     = '0;
        hit2     = '0;
        wake     = '0;
        eligible = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit1[i] = bus.cdb_valid_i && (state_q[i] == ST_WAIT) && !s1_rdy_q[i] &&
                      (s1_tag_q[i] == bus.cdb_tag_i);
            hit2[i] = bus.cdb_valid_i && (state_q[i] == ST_WAIT) && !s2_rdy_q[i] &&
                      (s2_tag_q[i] == bus.cdb_tag_i);
            wake[i] = (state_q[i] == ST_WAIT) && (s1_rdy_q[i] || hit1[i]) &&
                      (s2_rdy_q[i] || hit2[i]);
`ifdef RS_WAKEUP_BYPASS_EN
            eligible[i] = (state_q[i] == ST_READY) || wake[i];
`else
            eligible[i] = (state_q[i] == ST_READY);
`endif
        end
    end

    // lowest-index empty slot for allocation; free derives from registered state only
    always_comb begin
        free      = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_EMPTY && !free) begin
                free      = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // oldest eligible entry: eligible and no eligible entry allocated before it
    always_comb begin
        any_eligible = 1'b0;
        pick_idx     = '0;
        blocked      = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (eligible[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (eligible[i] && !blocked && !any_eligible) begin
                any_eligible = 1'b1;
                pick_idx     = IDX_W'(i);
            end
        end
    end

    assign sel_idx  = lock_q ? lock_idx_q : pick_idx;
    assign fu_valid = !bus.flush_i && (lock_q || any_eligible);
    assign hs       = fu_valid && bus.fu_ready_i;
    assign do_load  = bus.load_i && free;
    assign ld_hit1  = bus.cdb_valid_i && (bus.cdb_tag_i == bus.src1_tag_i);
    assign ld_hit2  = bus.cdb_valid_i && (bus.cdb_tag_i == bus.src2_tag_i);

    // functional-unit outputs, zeroed whenever nothing is presented
    always_comb begin
        bus.free_o     = free;
        bus.fu_valid_o = fu_valid;
        bus.fu_op_o    = '0;
        bus.fu_tag_o   = '0;
        bus.fu_a_o     = '0;
        bus.fu_b_o     = '0;
        if (fu_valid) begin
            bus.fu_op_o  = op_q[sel_idx];
            bus.fu_tag_o = dest_q[sel_idx];
            bus.fu_a_o   = s1_val_q[sel_idx];
            bus.fu_b_o   = s2_val_q[sel_idx];
`ifdef RS_WAKEUP_BYPASS_EN
            if (hit1[sel_idx]) bus.fu_a_o = bus.cdb_data_i;
            if (hit2[sel_idx]) bus.fu_b_o = bus.cdb_data_i;
`endif
        end
    end

    // entry state, operand capture, allocation, age order and dispatch lock
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i]  <= ST_EMPTY;
                op_q[i]     <= '0;
                dest_q[i]   <= '0;
                s1_rdy_q[i] <= 1'b0;
                s1_tag_q[i] <= '0;
                s1_val_q[i] <= '0;
                s2_rdy_q[i] <= 1'b0;
                s2_tag_q[i] <= '0;
                s2_val_q[i] <= '0;
                older_q[i]  <= '0;
            end
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (bus.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) state_q[i] <= ST_EMPTY;
            lock_q <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (hit1[i]) begin
                    s1_rdy_q[i] <= 1'b1;
                    s1_val_q[i] <= bus.cdb_data_i;
                end
                if (hit2[i]) begin
                    s2_rdy_q[i] <= 1'b1;
                    s2_val_q[i] <= bus.cdb_data_i;
                end
                if (wake[i]) state_q[i] <= ST_READY;
                if (hs && sel_idx == IDX_W'(i)) state_q[i] <= ST_EMPTY;
            end
            if (do_load) begin
                op_q[alloc_idx]     <= bus.op_i;
                dest_q[alloc_idx]   <= bus.dest_tag_i;
                s1_tag_q[alloc_idx] <= bus.src1_tag_i;
                s2_tag_q[alloc_idx] <= bus.src2_tag_i;
                s1_rdy_q[alloc_idx] <= bus.src1_rdy_i || ld_hit1;
                s2_rdy_q[alloc_idx] <= bus.src2_rdy_i || ld_hit2;
                s1_val_q[alloc_idx] <= bus.src1_rdy_i ? bus.src1_val_i : bus.cdb_data_i;
                s2_val_q[alloc_idx] <= bus.src2_rdy_i ? bus.src2_val_i : bus.cdb_data_i;
                state_q[alloc_idx]  <= ((bus.src1_rdy_i || ld_hit1) && (bus.src2_rdy_i || ld_hit2))
                                       ? ST_READY : ST_WAIT;
                for (int j = 0; j < ENTRIES; j++) begin
                    older_q[j][alloc_idx] <= (state_q[j] != ST_EMPTY) &&
                                             !(hs && sel_idx == IDX_W'(j));
                end
                older_q[alloc_idx] <= '0;
            end
            if (hs) begin
                lock_q <= 1'b0;
            end else if (fu_valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel_idx;
            end
        end
    end

    // the issue queue must never load into a full station; such a load is dropped
    a_load_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.load_i |-> free)
        else $warning("res_station: load_i with no free entry, op dropped");
endmodule
